// File: rtl/cpu_run_controller.sv
// rtl/cpu_run_controller.sv - board-side run sequencer for the pipelined CPU
// Define PC_TRACE_EN to build the circular PC trace buffer behind trace_rd_pc.
module cpu_run_controller #(
  parameter int RESET_CYCLES   = 4,
  parameter int TIMEOUT_CYCLES = 10000,
  parameter int HALT_STABLE    = 8,
  parameter int TRACE_DEPTH    = 8,
  localparam int TAW = (TRACE_DEPTH > 1) ? $clog2(TRACE_DEPTH) : 1
) (
  input  logic           input_clk,
  input  logic           rst,
  input  logic           start,
  input  logic           abort,
  input  logic [31:0]    PC,
  input  logic [31:0]    cycles_consumed,
  output logic           cpu_rst,
  output logic           running,
  output logic           done,
  output logic           halted,
  output logic           timeout,
  output logic [31:0]    cycles_result,
  output logic [31:0]    final_pc,
  input  logic [TAW-1:0] trace_rd_idx,
  output logic [31:0]    trace_rd_pc
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RESET = 2'd1, S_RUN = 2'd2, S_DONE = 2'd3} state_t;

  localparam logic [31:0] RST_LAST  = 32'(RESET_CYCLES - 1);
  localparam logic [31:0] TMO_LAST  = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0] HALT_LAST = 32'(HALT_STABLE - 1);

  state_t      state, state_next;
  logic [31:0] rst_cnt, run_cnt, stable_cnt, prev_pc;
  logic        prev_valid;
  logic        pc_eq, halt_det, tmo_det, capture, enter_reset;

  always_comb begin
    state_next  = state;
    halt_det    = 1'b0;
    tmo_det     = 1'b0;
    capture     = 1'b0;
    // prev_valid is low in the first RUN cycle, so that cycle never counts as stable
    pc_eq       = prev_valid && (PC == prev_pc);
    case (state)
      S_IDLE:  if (start) state_next = S_RESET;
      S_RESET: if (rst_cnt == RST_LAST) state_next = S_RUN;
      S_RUN: begin
        halt_det = pc_eq && (stable_cnt == HALT_LAST);
        tmo_det  = (run_cnt == TMO_LAST);
        if (abort) begin
          state_next = S_IDLE;
        end else if (halt_det || tmo_det) begin
          state_next = S_DONE;
          capture    = 1'b1;
        end
      end
      S_DONE:  if (start) state_next = S_RESET;
      default: state_next = S_IDLE;
    endcase
    enter_reset = (state_next == S_RESET) && (state != S_RESET);
  end

  always_ff @(posedge input_clk) begin
    if (rst) begin
      state         <= S_IDLE;
      cpu_rst       <= 1'b1;
      running       <= 1'b0;
      done          <= 1'b0;
      halted        <= 1'b0;
      timeout       <= 1'b0;
      cycles_result <= 32'd0;
      final_pc      <= 32'd0;
      rst_cnt       <= 32'd0;
      run_cnt       <= 32'd0;
      stable_cnt    <= 32'd0;
      prev_pc       <= 32'd0;
      prev_valid    <= 1'b0;
    end else begin
      state   <= state_next;
      cpu_rst <= (state_next != S_RUN);
      running <= (state_next == S_RUN);
      done    <= (state_next == S_DONE);
      rst_cnt <= (state == S_RESET) ? rst_cnt + 32'd1 : 32'd0;
      if (state == S_RUN) begin
        run_cnt    <= run_cnt + 32'd1;
        prev_pc    <= PC;
        prev_valid <= 1'b1;
        if (!pc_eq)
          stable_cnt <= 32'd0;
        else if (stable_cnt != HALT_LAST)
          stable_cnt <= stable_cnt + 32'd1;
      end else begin
        run_cnt    <= 32'd0;
        stable_cnt <= 32'd0;
        prev_valid <= 1'b0;
      end
      if (enter_reset) begin
        halted  <= 1'b0;
        timeout <= 1'b0;
      end
      // halt wins a tie with timeout
      if (capture) begin
        final_pc      <= PC;
        cycles_result <= cycles_consumed + 32'd1;
        halted        <= halt_det;
        timeout       <= !halt_det;
      end
    end
  end

`ifdef PC_TRACE_EN
  logic [31:0]    trace_buf [TRACE_DEPTH];
  logic [TAW-1:0] wr_ptr;
  logic [TAW-1:0] rd_ptr;
  logic           trace_we;

  assign trace_we = (state == S_RUN) && !pc_eq;
  assign rd_ptr   = wr_ptr - trace_rd_idx - 1'b1;
  assign trace_rd_pc = trace_buf[rd_ptr];

  always_ff @(posedge input_clk) begin
    if (rst || enter_reset) begin
      wr_ptr <= '0;
      for (int i = 0; i < TRACE_DEPTH; i++) trace_buf[i] <= 32'd0;
    end else if (trace_we) begin
      trace_buf[wr_ptr] <= PC;
      wr_ptr            <= wr_ptr + 1'b1;
    end
  end
`else
  logic unused_trace_idx;
  assign unused_trace_idx = ^trace_rd_idx;
  assign trace_rd_pc      = 32'd0;
`endif

endmodule

// File: tb/tb_cpu_run_controller.sv
// tb/tb_cpu_run_controller.sv - directed bench for cpu_run_controller
module tb_cpu_run_controller;

  localparam int RC = 4;
  localparam int TC = 40;
  localparam int HS = 8;
  localparam int TD = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [31:0] pc = 32'd0;
  logic [31:0] cc = 32'd0;
  logic [2:0]  rd_idx = 3'd0;
  logic        cpu_rst, running, done, halted, timeout;
  logic [31:0] cycles_result, final_pc, trace_rd_pc;

  int checks = 0;
  int errors = 0;

  cpu_run_controller #(
    .RESET_CYCLES(RC), .TIMEOUT_CYCLES(TC), .HALT_STABLE(HS), .TRACE_DEPTH(TD)
  ) dut (
    .input_clk(clk), .rst(rst), .start(start), .abort(abort),
    .PC(pc), .cycles_consumed(cc),
    .cpu_rst(cpu_rst), .running(running), .done(done),
    .halted(halted), .timeout(timeout),
    .cycles_result(cycles_result), .final_pc(final_pc),
    .trace_rd_idx(rd_idx), .trace_rd_pc(trace_rd_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, start, abort;
    logic [31:0] pc;
    logic        e_cpu_rst, e_running, e_done, e_halted, e_timeout;
    logic [31:0] e_cres;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] pc_of(input int mode, input int k);
    case (mode)
      1:       return (k < 16) ? 32'(4 * k) : 32'h40;
      2:       return 32'h100 + 32'(4 * k);
      3:       return (k < 32) ? 32'(4 * k) : 32'd124;
      4:       return 32'h80;
      default: return (k == 0) ? 32'd0 : (k == 1) ? 32'd4 : (k <= 3) ? 32'd8 : 32'd12;
    endcase
  endfunction

  task automatic do_start(output int nhi);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    nhi = 0;
    for (int i = 0; i < 20; i++) begin
      if (!cpu_rst) break;
      nhi++;
      @(posedge clk); #1;
    end
  endtask

  task automatic run_until_done(input int mode, output int det, output int gaps);
    det  = -1;
    gaps = 0;
    for (int k = 0; k < 200; k++) begin
      if (!running) gaps++;
      pc = pc_of(mode, k);
      cc = 32'(k);
      @(posedge clk); #1;
      if (done) begin
        det = k;
        break;
      end
    end
  endtask

  vec_t vt[13];
  int   n, d, g;

  initial begin
    // reset, RESET window with ignored start/abort, abort in RUN cycle 5
    vt[0]  = '{1'b1, 1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0};
    vt[1]  = '{1'b0, 1'b1, 1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0};
    vt[2]  = '{1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0};
    vt[3]  = '{1'b0, 1'b1, 1'b1, 32'h0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0};
    vt[4]  = '{1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0};
    vt[5]  = '{1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0};
    vt[6]  = '{1'b0, 1'b0, 1'b0, 32'h10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0};
    vt[7]  = '{1'b0, 1'b0, 1'b0, 32'h14, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0};
    vt[8]  = '{1'b0, 1'b0, 1'b0, 32'h18, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0};
    vt[9]  = '{1'b0, 1'b0, 1'b0, 32'h1c, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0};
    vt[10] = '{1'b0, 1'b0, 1'b0, 32'h20, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0};
    vt[11] = '{1'b0, 1'b0, 1'b1, 32'h24, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0};
    vt[12] = '{1'b0, 1'b0, 1'b0, 32'h28, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0};

    #2;
    for (int i = 0; i < 13; i++) begin
      rst   = vt[i].rst;
      start = vt[i].start;
      abort = vt[i].abort;
      pc    = vt[i].pc;
      cc    = 32'd7;
      @(posedge clk); #1;
      chk($sformatf("vec%0d cpu_rst", i), {31'd0, cpu_rst}, {31'd0, vt[i].e_cpu_rst});
      chk($sformatf("vec%0d running", i), {31'd0, running}, {31'd0, vt[i].e_running});
      chk($sformatf("vec%0d done", i),    {31'd0, done},    {31'd0, vt[i].e_done});
      chk($sformatf("vec%0d halted", i),  {31'd0, halted},  {31'd0, vt[i].e_halted});
      chk($sformatf("vec%0d timeout", i), {31'd0, timeout}, {31'd0, vt[i].e_timeout});
      chk($sformatf("vec%0d cycles_result", i), cycles_result, vt[i].e_cres);
      chk($sformatf("vec%0d final_pc", i), final_pc, 32'd0);
    end
    rst = 1'b0; start = 1'b0; abort = 1'b0;

    // halt: PC climbs by 4 and sticks at 0x40
    do_start(n);
    chk("t1 cpu_rst high cycles", 32'(n), 32'd4);
    run_until_done(1, d, g);
    chk("t1 running gaps", 32'(g), 32'd0);
    chk("t1 done delay after first repeat", 32'(d - 16), 32'd8);
    chk("t1 halted", {31'd0, halted}, 32'd1);
    chk("t1 timeout", {31'd0, timeout}, 32'd0);
    chk("t1 final_pc", final_pc, 32'h40);
    chk("t1 cycles_result", cycles_result, 32'd25);
    chk("t1 running after done", {31'd0, running}, 32'd0);
    chk("t1 cpu_rst in done", {31'd0, cpu_rst}, 32'd1);

    // timeout: PC never repeats; restart from DONE keeps old result
    do_start(n);
    chk("t2 halted cleared", {31'd0, halted}, 32'd0);
    chk("t2 cycles_result kept", cycles_result, 32'd25);
    run_until_done(2, d, g);
    chk("t2 run length", 32'(d + 1), 32'd40);
    chk("t2 timeout", {31'd0, timeout}, 32'd1);
    chk("t2 halted", {31'd0, halted}, 32'd0);
    chk("t2 cycles_result", cycles_result, 32'd40);
    chk("t2 final_pc", final_pc, 32'h19c);

    // halt and timeout land on the same cycle
    do_start(n);
    run_until_done(3, d, g);
    chk("t3 done cycle", 32'(d), 32'd39);
    chk("t3 halted", {31'd0, halted}, 32'd1);
    chk("t3 timeout", {31'd0, timeout}, 32'd0);
    chk("t3 final_pc", final_pc, 32'd124);

    // rst mid-RESET
    start = 1'b1; @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
    chk("t5a cpu_rst", {31'd0, cpu_rst}, 32'd1);
    chk("t5a running", {31'd0, running}, 32'd0);
    chk("t5a halted", {31'd0, halted}, 32'd0);
    chk("t5a cycles_result", cycles_result, 32'd0);
    chk("t5a final_pc", final_pc, 32'd0);

    // rst mid-RUN
    do_start(n);
    for (int k = 0; k < 3; k++) begin
      pc = 32'(k * 4); @(posedge clk); #1;
    end
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
    chk("t5b cpu_rst", {31'd0, cpu_rst}, 32'd1);
    chk("t5b running", {31'd0, running}, 32'd0);
    chk("t5b done", {31'd0, done}, 32'd0);

    // normal run after reset: constant PC halts after HS equal samples
    do_start(n);
    chk("t5c cpu_rst high cycles", 32'(n), 32'd4);
    run_until_done(4, d, g);
    chk("t5c done cycle", 32'(d), 32'd8);
    chk("t5c halted", {31'd0, halted}, 32'd1);
    chk("t5c final_pc", final_pc, 32'h80);
    chk("t5c cycles_result", cycles_result, 32'd9);

    // trace run: 0,4,8,8,12 then stuck at 12
    do_start(n);
    run_until_done(5, d, g);
    chk("t6 done cycle", 32'(d), 32'd12);
    chk("t6 final_pc", final_pc, 32'd12);
    for (int i = 0; i < 5; i++) begin
      logic [31:0] exp_tr;
`ifdef PC_TRACE_EN
      exp_tr = (i == 0) ? 32'd12 : (i == 1) ? 32'd8 : (i == 2) ? 32'd4 : 32'd0;
`else
      exp_tr = 32'd0;
`endif
      rd_idx = 3'(i);
      #1;
      chk($sformatf("t6 trace idx%0d", i), trace_rd_pc, exp_tr);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
